// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter that lends one shared Booth multiplier to N_REQ requesters.
// Each grant runs IDLE -> LAUNCH -> WAIT -> RESP; WAIT aborts with an error after TIMEOUT cycles.
module booth_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   op_a,
  input  logic [N_REQ*WIDTH-1:0]   op_b,
  output logic [N_REQ-1:0]         ack,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mul_start,
  output logic                     mul_rst,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, gnt_id_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               err_q;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;

  logic [WIDTH-1:0]   a_arr [N_REQ];
  logic [WIDTH-1:0]   b_arr [N_REQ];
  logic               win_found;
  logic [PW-1:0]      win_id, sel;
  int                 idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign a_arr[g] = op_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = op_b[g*WIDTH +: WIDTH];
  end

  // First requester at or after ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    sel       = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = PW'(idx);
      if (!win_found && req[sel]) begin
        win_found = 1'b1;
        win_id    = sel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (mul_done || cnt_q == CW'(TIMEOUT-1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_id_q <= win_id;
            mul_a_q  <= a_arr[win_id];
            mul_b_q  <= b_arr[win_id];
          end
        end
        LAUNCH: cnt_q <= '0;
        WAIT: begin
          // mul_done wins over a simultaneous timeout.
          if (mul_done) begin
            prod_q <= mul_product;
            err_q  <= 1'b0;
          end else if (cnt_q == CW'(TIMEOUT-1)) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: ptr_q <= (gnt_id_q == PW'(N_REQ-1)) ? '0 : gnt_id_q + PW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    ack         = '0;
    rsp_product = '0;
    rsp_err     = 1'b0;
    if (!rst && state_q == RESP) begin
      ack[gnt_id_q] = 1'b1;
      rsp_product   = prod_q;
      rsp_err       = err_q;
    end
  end

  assign busy      = !rst && (state_q != IDLE);
  assign mul_start = !rst && (state_q == LAUNCH);
  assign mul_rst   = rst || (state_q == RESP);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: behavioural multiplier model plus an ack scoreboard.
module tb_booth_mult_arbiter;
  localparam int N_REQ   = 4;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [63:0]  op_a = '0, op_b = '0;
  logic [3:0]   ack;
  logic [31:0]  rsp_product;
  logic         rsp_err, busy, mul_start, mul_rst, mul_done;
  logic [15:0]  mul_a, mul_b;
  logic [31:0]  mul_product = '0;

  booth_mult_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .rsp_product(rsp_product), .rsp_err(rsp_err), .busy(busy),
    .mul_start(mul_start), .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, ack_cnt = 0;
  logic [35:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [35:0] mk(input int id, input logic err, input logic [31:0] p);
    return {err, 3'(id), p};
  endfunction

  // Multiplier model: done rises mdelay cycles after mul_start (never if mdelay==0), held until mul_rst.
  logic done_q = 1'b0, active = 1'b0, sticky = 1'b0;
  int   mdelay = 1, mcnt = 0;
  assign mul_done = done_q | sticky;
  always @(posedge clk) begin
    if (mul_rst) begin
      done_q <= 1'b0; active <= 1'b0; mcnt <= 0;
    end else if (mul_start) begin
      mul_product <= smul(mul_a, mul_b);
      active <= 1'b1; mcnt <= 1; done_q <= (mdelay == 1);
    end else if (active && !done_q && mdelay != 0) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == mdelay) done_q <= 1'b1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [35:0] e;
    logic [3:0]  ea;
    if (mul_start) begin start_cnt++; start_cyc = cyc; end
    if (ack != '0) begin
      ack_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL unexpected_ack ack=%b rsp=%h err=%b, required no ack", ack, rsp_product, rsp_err);
      end else begin
        e  = exp_q.pop_front();
        ea = 4'b0001 << e[34:32];
        total += 3;
        if (ack !== ea) begin bad++; $display("FAIL ack_id got=%b exp=%b", ack, ea); end
        if (rsp_product !== e[31:0]) begin bad++; $display("FAIL rsp_product got=%h exp=%h", rsp_product, e[31:0]); end
        if (rsp_err !== e[35]) begin bad++; $display("FAIL rsp_err got=%b exp=%b", rsp_err, e[35]); end
      end
    end else begin
      total++;
      if (rsp_product !== '0 || rsp_err !== 1'b0) begin
        bad++; $display("FAIL idle_rsp got=%h/%b exp=0/0", rsp_product, rsp_err);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_one(input int id, input logic [15:0] a, input logic [15:0] b, input int dly,
                         input logic [35:0] e, output int t0, output int tack);
    logic ok;
    @(negedge clk);
    op_a[id*16 +: 16] = a; op_b[id*16 +: 16] = b; mdelay = dly;
    exp_q.push_back(e);
    req[id] = 1'b1; t0 = cyc; ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ack[id]) begin ok = 1'b1; break; end
    end
    tack = cyc; req[id] = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL ack_wait id=%0d got no ack in 200 cycles, required ack", id); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; sticky = 1'b0; mdelay = 1;
    repeat (3) @(negedge clk);
    total += 4;
    if (ack !== 4'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ack_busy got=%b/%b exp=0000/0", ack, busy); end
    if (mul_start !== 1'b0 || mul_rst !== 1'b1) begin bad++; $display("FAIL reset_mul_ctl got=%b/%b exp=0/1", mul_start, mul_rst); end
    if (mul_a !== 16'h0 || mul_b !== 16'h0) begin bad++; $display("FAIL reset_operands got=%h/%h exp=0/0", mul_a, mul_b); end
    if (rsp_product !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_product, rsp_err); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mul_rst !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset got mul_rst=%b busy=%b exp=0/0", mul_rst, busy); end
  endtask

  task automatic test_single();
    int t0, tack, s0;
    s0 = start_cnt;
    run_one(0, 16'd3, 16'hFFFB, 10, mk(0, 1'b0, 32'hFFFF_FFF1), t0, tack);
    total += 3;
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_starts got=%0d exp=1", start_cnt - s0); end
    if (start_cyc != t0 + 1) begin bad++; $display("FAIL single_start_cyc got=%0d exp=%0d", start_cyc, t0 + 1); end
    if (tack != t0 + 12) begin bad++; $display("FAIL single_ack_cyc got=%0d exp=%0d", tack, t0 + 12); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_contention();
    logic [15:0] a[4], b[4];
    int got;
    logic ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'($urandom_range(0, 65535)); b[i] = 16'($urandom_range(0, 65535));
      op_a[i*16 +: 16] = a[i]; op_b[i*16 +: 16] = b[i];
    end
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(k % 4, 1'b0, smul(a[k % 4], b[k % 4])));
    mdelay = $urandom_range(1, 5);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      ok = 1'b0; got = -1;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (ack != '0) begin ok = 1'b1; break; end
      end
      for (int i = 0; i < 4; i++) if (ack[i]) got = i;
      total++;
      if (!ok || got != k % 4) begin bad++; $display("FAIL rr_order step=%0d got=%0d exp=%0d", k, got, k % 4); end
      mdelay = $urandom_range(1, 5);
      if (k == 4) req = '0;
      else if (got >= 0) begin
        req[got] = 1'b0;
        @(negedge clk);
        req[got] = 1'b1;
      end
    end
  endtask

  task automatic test_sticky();
    int t0, tack, a0, s0;
    run_one(1, 16'd7, 16'd9, 2, mk(1, 1'b0, 32'd63), t0, tack);
    sticky = 1'b1;
    s0 = start_cnt;
    run_one(2, 16'hFF9C, 16'd55, 5, mk(2, 1'b0, 32'hFFFF_EA84), t0, tack);
    @(negedge clk);
    a0 = ack_cnt;
    repeat (10) @(negedge clk);
    total += 3;
    if (tack != t0 + 3) begin bad++; $display("FAIL sticky_ack_cyc got=%0d exp=%0d", tack, t0 + 3); end
    if (ack_cnt != a0) begin bad++; $display("FAIL sticky_extra_ack got=%0d exp=0", ack_cnt - a0); end
    if (start_cnt - s0 != 1) begin bad++; $display("FAIL sticky_starts got=%0d exp=1", start_cnt - s0); end
    sticky = 1'b0;
  endtask

  task automatic test_timeout();
    int t0, tack;
    run_one(3, 16'd100, 16'd200, 0, mk(3, 1'b1, 32'h0), t0, tack);
    total += 2;
    if (tack != t0 + TIMEOUT + 2) begin bad++; $display("FAIL timeout_ack_cyc got=%0d exp=%0d", tack, t0 + TIMEOUT + 2); end
    if (mul_rst !== 1'b1) begin bad++; $display("FAIL timeout_mul_rst got=%b exp=1", mul_rst); end
    @(negedge clk);
    total++;
    if (mul_rst !== 1'b0) begin bad++; $display("FAIL timeout_mul_rst_len got=%b exp=0", mul_rst); end
  endtask

  task automatic test_reset_wait();
    logic ok;
    @(negedge clk);
    mdelay = 0; op_a[47:32] = 16'd11; op_b[47:32] = 16'd13; req[2] = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rw_busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mul_rst !== 1'b1 || busy !== 1'b0 || ack !== 4'b0) begin
      bad++; $display("FAIL rw_in_reset got mul_rst=%b busy=%b ack=%b exp=1/0/0000", mul_rst, busy, ack);
    end
    req = 4'hF;
    for (int i = 0; i < 4; i++) begin op_a[i*16 +: 16] = 16'(i + 2); op_b[i*16 +: 16] = 16'hFFFF; end
    @(negedge clk);
    rst = 1'b0; mdelay = 3;
    exp_q.push_back(mk(0, 1'b0, 32'hFFFF_FFFE));
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ack != '0) begin ok = 1'b1; break; end
    end
    req = '0;
    total++;
    if (!ok || ack !== 4'b0001) begin bad++; $display("FAIL rw_regrant got=%b exp=0001", ack); end
  endtask

  task automatic test_extremes();
    int t0, tack;
    run_one(0, 16'h8000, 16'h8000, 3, mk(0, 1'b0, 32'h4000_0000), t0, tack);
    run_one(1, 16'h8000, 16'h0001, 2, mk(1, 1'b0, 32'hFFFF_8000), t0, tack);
  endtask

  task automatic test_random();
    int t0, tack, id, d;
    logic [15:0] a, b;
    for (int k = 0; k < 8; k++) begin
      id = $urandom_range(0, 3); d = $urandom_range(1, 8);
      a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
      run_one(id, a, b, d, mk(id, 1'b0, smul(a, b)), t0, tack);
      total++;
      if (tack != t0 + d + 2) begin bad++; $display("FAIL rand_ack_cyc got=%0d exp=%0d", tack, t0 + d + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_sticky();
    test_timeout();
    test_reset_wait();
    test_extremes();
    test_random();
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain pending=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
